// File: rtl/io_timer_responder_if.sv
// FemtoRV32 IO-window bus between the CPU (master) and the timer/port responder (slave).
interface io_timer_responder_if;
  logic        io_sel;
  logic [7:0]  io_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;
  logic        mem_rbusy;
  logic        mem_wbusy;

  modport master (
    output io_sel, io_addr, mem_wdata, mem_wmask, mem_rstrb,
    input  mem_rdata, mem_rbusy, mem_wbusy
  );

  modport slave (
    input  io_sel, io_addr, mem_wdata, mem_wmask, mem_rstrb,
    output mem_rdata, mem_rbusy, mem_wbusy
  );
endinterface

// File: rtl/io_timer_responder.sv
// IO-window responder: output port, prescaled tick counter, compare/interrupt latch, wait-stated reads.
// Define IO_TIMER_PERIODIC_EN to implement CTRL[2] (auto-reload of ticks on compare match).
module io_timer_responder #(
  parameter int unsigned TICK_DIV  = 48,
  parameter int unsigned READ_WAIT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  io_timer_responder_if.slave   bus,
  output logic [7:0]            port_a,
  output logic                  interrupt_request
);

  localparam int unsigned DW = 32;
  localparam int unsigned IW = 6;
  localparam int unsigned CW = 4;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(READ_WAIT - 1);

  localparam logic [IW-1:0] IDX_PORT    = IW'(0);
  localparam logic [IW-1:0] IDX_TICKS   = IW'(1);
  localparam logic [IW-1:0] IDX_COMPARE = IW'(2);
  localparam logic [IW-1:0] IDX_CTRL    = IW'(3);

  typedef enum logic [0:0] {S_IDLE, S_WAIT} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic           rbusy_q, rbusy_d;
  logic [7:0]     port_q, port_d;
  logic [DW-1:0]  ticks_q, ticks_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [DW-1:0]  compare_q, compare_d;
  logic           irq_en_q, irq_en_d;
  logic           pending_q, pending_d;
  logic           periodic_q, periodic_d;
  logic           irq_q, irq_d;

  logic           wr_c;
  logic [IW-1:0]  wr_idx_c;
  logic           ticks_wr_c;
  logic           tick_c;
  logic           match_c;
  logic [IW-1:0]  rd_idx_c;
  logic [DW-1:0]  rd_val_c;
  logic           addr_lsb_unused_c;

  assign addr_lsb_unused_c = ^bus.io_addr[1:0];

  assign wr_c       = bus.io_sel & (|bus.mem_wmask);
  assign wr_idx_c   = bus.io_addr[7:2];
  assign ticks_wr_c = wr_c && (wr_idx_c == IDX_TICKS);
  assign tick_c     = (presc_q == PRESC_MAX);
  // A TICKS write in the same cycle suppresses the match; compare is always the pre-edge value.
  assign match_c    = tick_c && !ticks_wr_c && ((ticks_q + 32'd1) == compare_q);

  // Read source: the strobe's index on a zero-wait read, the latched index at the end of WAIT.
  assign rd_idx_c = (state_q == S_WAIT) ? idx_q : bus.io_addr[7:2];

  always_comb begin
    rd_val_c = '0;
    case (rd_idx_c)
      IDX_PORT:    rd_val_c = {24'h0, port_q};
      IDX_TICKS:   rd_val_c = ticks_q;
      IDX_COMPARE: rd_val_c = compare_q;
      IDX_CTRL:    rd_val_c = {29'h0, periodic_q, pending_q, irq_en_q};
      default:     rd_val_c = '0;
    endcase
  end

  // Read FSM next-state and registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    rbusy_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.io_sel && bus.mem_rstrb) begin
          if (READ_WAIT == 0) begin
            rdata_d = rd_val_c;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
            idx_d   = bus.io_addr[7:2];
            rbusy_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = rd_val_c;
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q - CW'(1);
          rbusy_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register writes, prescaler/tick counter and interrupt latch.
  always_comb begin
    port_d     = port_q;
    ticks_d    = ticks_q;
    presc_d    = presc_q;
    compare_d  = compare_q;
    irq_en_d   = irq_en_q;
    pending_d  = pending_q;
    periodic_d = periodic_q;
    irq_d      = pending_q & irq_en_q;

    if (ticks_wr_c) begin
      ticks_d = '0;
      presc_d = '0;
    end else if (tick_c) begin
      presc_d = '0;
      ticks_d = (match_c && periodic_q) ? '0 : ticks_q + 32'd1;
    end else begin
      presc_d = presc_q + PW'(1);
    end

    if (wr_c) begin
      case (wr_idx_c)
        IDX_PORT: begin
          if (bus.mem_wmask[0]) port_d = bus.mem_wdata[7:0];
        end
        IDX_COMPARE: begin
          for (int unsigned b = 0; b < 4; b++) begin
            if (bus.mem_wmask[b]) compare_d[8*b +: 8] = bus.mem_wdata[8*b +: 8];
          end
        end
        IDX_CTRL: begin
          if (bus.mem_wmask[0]) begin
            irq_en_d = bus.mem_wdata[0];
            if (bus.mem_wdata[1]) pending_d = 1'b0;
`ifdef IO_TIMER_PERIODIC_EN
            periodic_d = bus.mem_wdata[2];
`else
            periodic_d = 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end

    // A match on the same edge as a clear keeps the interrupt pending.
    if (match_c) pending_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      rdata_q    <= '0;
      rbusy_q    <= 1'b0;
      port_q     <= '0;
      ticks_q    <= '0;
      presc_q    <= '0;
      compare_q  <= '1;
      irq_en_q   <= 1'b0;
      pending_q  <= 1'b0;
      periodic_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      rdata_q    <= rdata_d;
      rbusy_q    <= rbusy_d;
      port_q     <= port_d;
      ticks_q    <= ticks_d;
      presc_q    <= presc_d;
      compare_q  <= compare_d;
      irq_en_q   <= irq_en_d;
      pending_q  <= pending_d;
      periodic_q <= periodic_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.mem_rdata     = rdata_q;
  assign bus.mem_rbusy     = rbusy_q;
  assign bus.mem_wbusy     = 1'b0;
  assign port_a            = port_q;
  assign interrupt_request = irq_q;

endmodule

// File: tb/tb_io_timer_responder.sv
// Bench for io_timer_responder: directed steps plus random bus traffic against a cycle reference model.
module tb_io_timer_responder;
  localparam int unsigned TICK_DIV  = 4;
  localparam int unsigned READ_WAIT = 2;
`ifdef IO_TIMER_PERIODIC_EN
  localparam bit PER_EN = 1'b1;
`else
  localparam bit PER_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] port_a;
  logic       interrupt_request;

  io_timer_responder_if bus();

  io_timer_responder #(.TICK_DIV(TICK_DIV), .READ_WAIT(READ_WAIT)) dut (
    .clk               (clk),
    .reset             (reset),
    .bus               (bus),
    .port_a            (port_a),
    .interrupt_request (interrupt_request)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [7:0]  m_port;
  logic [31:0] m_ticks, m_cmp, m_rdata;
  int unsigned m_phase;
  bit          m_en, m_pend, m_per, m_irq;
  bit          m_rd_out;
  longint      m_rd_due;
  int          m_rd_idx;
  longint      m_edge = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input int idx);
    case (idx)
      0:       return {24'h0, m_port};
      1:       return m_ticks;
      2:       return m_cmp;
      3:       return {29'h0, m_per, m_pend, m_en};
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    m_port = '0; m_ticks = '0; m_cmp = 32'hFFFF_FFFF; m_rdata = '0;
    m_phase = 0; m_en = 0; m_pend = 0; m_per = 0; m_irq = 0; m_rd_out = 0;
  endtask

  // One rising edge of the reference: everything derived from pre-edge state and current inputs.
  task automatic m_step();
    int idx;
    bit wr, tick, tclr, match, clr;
    m_edge++;
    if (!reset) begin
      m_reset();
      return;
    end
    idx = int'(bus.io_addr[7:2]);
    wr  = bus.io_sel && (bus.mem_wmask != 4'h0);
    if (m_rd_out && m_edge == m_rd_due) begin
      m_rdata  = m_read(m_rd_idx);
      m_rd_out = 0;
    end else if (!m_rd_out && bus.io_sel && bus.mem_rstrb) begin
      if (READ_WAIT == 0) m_rdata = m_read(idx);
      else begin
        m_rd_out = 1; m_rd_due = m_edge + longint'(READ_WAIT); m_rd_idx = idx;
      end
    end
    m_irq = m_pend && m_en;
    tick  = ((m_phase + 1) % TICK_DIV) == 0;
    tclr  = wr && idx == 1;
    match = tick && !tclr && ((m_ticks + 32'd1) == m_cmp);
    if (tclr) begin
      m_ticks = '0; m_phase = 0;
    end else begin
      m_phase++;
      if (tick) m_ticks = (match && m_per) ? 32'h0 : m_ticks + 32'd1;
    end
    clr = 0;
    if (wr && idx == 0 && bus.mem_wmask[0]) m_port = bus.mem_wdata[7:0];
    if (wr && idx == 2)
      for (int b = 0; b < 4; b++) if (bus.mem_wmask[b]) m_cmp[8*b +: 8] = bus.mem_wdata[8*b +: 8];
    if (wr && idx == 3 && bus.mem_wmask[0]) begin
      m_en = bus.mem_wdata[0]; m_per = PER_EN && bus.mem_wdata[2]; clr = bus.mem_wdata[1];
    end
    if (match) m_pend = 1;
    else if (clr) m_pend = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    m_step();
    #1;
    chk("port_a", 32'(port_a), 32'(m_port));
    chk("irq", 32'(interrupt_request), 32'(m_irq));
    chk("rbusy", 32'(bus.mem_rbusy), 32'(m_rd_out));
    chk("rdata", bus.mem_rdata, m_rdata);
    chk("wbusy", 32'(bus.mem_wbusy), 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wr(input int idx, input logic [31:0] d, input logic [3:0] m);
    bus.io_sel = 1'b1; bus.io_addr = {6'(idx), 2'($urandom)};
    bus.mem_wdata = d; bus.mem_wmask = m; bus.mem_rstrb = 1'b0;
    cyc();
    bus.io_sel = 1'b0; bus.mem_wmask = 4'h0;
  endtask

  task automatic strobe(input int idx);
    bus.io_sel = 1'b1; bus.io_addr = {6'(idx), 2'($urandom)}; bus.mem_rstrb = 1'b1;
    cyc();
    bus.io_sel = 1'b0; bus.mem_rstrb = 1'b0;
  endtask

  task automatic rd(input int idx);
    strobe(idx);
    for (int i = 0; i < 16 && m_rd_out; i++) cyc();
    chk("rd_done", 32'(bus.mem_rbusy), 32'h0);
  endtask

  initial begin
    int r, idx;
    logic [31:0] d;
    reset = 1'b0;
    bus.io_sel = 1'b0; bus.io_addr = '0; bus.mem_wdata = '0; bus.mem_wmask = '0; bus.mem_rstrb = 1'b0;
    m_reset();

    // Reset and readback of the compare reset value
    idle(3);
    reset = 1'b1;
    idle(1);
    rd(2);
    chk("cmp_reset", bus.mem_rdata, 32'hFFFF_FFFF);

    // PORT_A uses lane 0 only
    wr(0, 32'h0000_00A5, 4'b0001);
    chk("port_a5", 32'(port_a), 32'h0000_00A5);
    wr(0, 32'h0000_3C3C, 4'b0010);
    chk("port_lane1", 32'(port_a), 32'h0000_00A5);

    // Read latency with two wait cycles
    strobe(3);
    chk("lat_c1", 32'(bus.mem_rbusy), 32'h1);
    cyc();
    chk("lat_c2", 32'(bus.mem_rbusy), 32'h1);
    cyc();
    chk("lat_c3", 32'(bus.mem_rbusy), 32'h0);
    chk("lat_data", bus.mem_rdata, 32'h0);

    // Compare match 20 cycles after a ticks clear, interrupt one cycle later
    wr(2, 32'd5, 4'hF);
    wr(3, 32'h1, 4'h1);
    wr(1, 32'h0, 4'h1);
    for (int i = 1; i <= 20; i++) begin
      cyc();
      chk("irq_quiet", 32'(interrupt_request), 32'h0);
    end
    cyc();
    chk("irq_rise", 32'(interrupt_request), 32'h1);
    wr(3, 32'h3, 4'h1);
    chk("irq_lag", 32'(interrupt_request), 32'h1);
    cyc();
    chk("irq_drop", 32'(interrupt_request), 32'h0);
    idle(30);
    chk("irq_stays_low", 32'(interrupt_request), 32'h0);
    wr(1, 32'h0, 4'h2);
    idle(21);
    chk("irq_rematch", 32'(interrupt_request), 32'h1);

    // Match and pending-clear on the same edge
    wr(3, 32'h3, 4'h1);
    wr(1, 32'h0, 4'h1);
    idle(19);
    wr(3, 32'h3, 4'h1);
    rd(3);
    chk("simul_clear", 32'(bus.mem_rdata[1]), 32'h1);

    // TICKS write on the tick edge suppresses the match
    wr(3, 32'h3, 4'h1);
    wr(1, 32'h0, 4'h1);
    idle(19);
    wr(1, 32'h0, 4'h8);
    rd(3);
    chk("simul_ticks", 32'(bus.mem_rdata[1]), 32'h0);

    // COMPARE write on the match edge: old compare still matches
    wr(1, 32'h0, 4'h1);
    idle(19);
    wr(2, 32'd7, 4'hF);
    rd(3);
    chk("simul_cmp", 32'(bus.mem_rdata[1]), 32'h1);

    // Periodic mode request; readback depends on build
    wr(3, 32'h7, 4'h1);
    wr(2, 32'd3, 4'hF);
    wr(1, 32'h0, 4'h1);
    rd(3);
    chk("ctrl_per", 32'(bus.mem_rdata[2]), 32'(PER_EN));
    for (int i = 0; i < 8; i++) begin
      rd(1);
      idle(1);
    end

    // Unmapped index reads zero
    rd(9);
    chk("unmapped", bus.mem_rdata, 32'h0);

    // Asynchronous reset during a read wait
    strobe(2);
    #3;
    reset = 1'b0;
    #1;
    m_reset();
    chk("rst_rbusy", 32'(bus.mem_rbusy), 32'h0);
    chk("rst_port", 32'(port_a), 32'h0);
    chk("rst_irq", 32'(interrupt_request), 32'h0);
    chk("rst_rdata", bus.mem_rdata, 32'h0);
    idle(2);
    reset = 1'b1;
    idle(1);

    // Random traffic
    wr(2, 32'd6, 4'hF);
    wr(3, 32'h1 | ($urandom & 32'h4), 4'h1);
    for (int n = 0; n < 1500; n++) begin
      r   = int'($urandom_range(0, 9));
      idx = (($urandom & 32'h1F) == 0) ? 63 : int'($urandom_range(0, 5));
      d   = (idx == 2) ? 32'($urandom_range(0, 12)) : $urandom;
      if (r < 3) wr(idx, d, 4'($urandom));
      else if (r < 5) strobe(idx);
      else if (r == 5) begin
        bus.io_sel = 1'b0; bus.io_addr = {6'(idx), 2'b00}; bus.mem_wdata = d; bus.mem_wmask = 4'hF;
        cyc();
        bus.mem_wmask = 4'h0;
      end else if (r == 6) begin
        bus.io_sel = 1'b0; bus.io_addr = {6'(idx), 2'b00}; bus.mem_rstrb = 1'b1;
        cyc();
        bus.mem_rstrb = 1'b0;
      end else cyc();
    end
    idle(READ_WAIT + 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
